// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register-file write port among ALU, load and mul/div writeback.
// Define RF_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority 0 > 1 > 2.
module regfile_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        req_valid,
    output logic [2:0]        req_ready,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [ADDR_W-1:0] req_addr2,
    input  logic [DATA_W-1:0] req_data0,
    input  logic [DATA_W-1:0] req_data1,
    input  logic [DATA_W-1:0] req_data2,
    output logic              reg_write,
    output logic [ADDR_W-1:0] addr3,
    output logic [DATA_W-1:0] wdata,
    output logic              idle
);
    logic [2:0]        buf_v_q, buf_v_d, grant, acc;
    logic [ADDR_W-1:0] buf_addr_q [3];
    logic [DATA_W-1:0] buf_data_q [3];
    logic [ADDR_W-1:0] in_addr [3];
    logic [DATA_W-1:0] in_data [3];
    logic [1:0]        gidx;
    logic              reg_write_q, reg_write_d;
    logic [ADDR_W-1:0] addr3_q;
    logic [DATA_W-1:0] wdata_q;

    assign in_addr = '{req_addr0, req_addr1, req_addr2};
    assign in_data = '{req_data0, req_data1, req_data2};

`ifdef RF_ARB_ROUND_ROBIN_EN
    logic [1:0] last_q;
    logic [2:0] rot_v, pick;
    // Rotate so the search start sits at bit 0, pick lowest, rotate back.
    always_comb begin
        rot_v = last_q == 2'd0 ? {buf_v_q[0], buf_v_q[2], buf_v_q[1]} :
                last_q == 2'd1 ? {buf_v_q[1], buf_v_q[0], buf_v_q[2]} : buf_v_q;
        pick  = rot_v[0] ? 3'b001 : rot_v[1] ? 3'b010 : rot_v[2] ? 3'b100 : 3'b000;
        grant = last_q == 2'd0 ? {pick[1], pick[0], pick[2]} :
                last_q == 2'd1 ? {pick[0], pick[2], pick[1]} : pick;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_q <= 2'd2;
        else if (|grant)
            last_q <= gidx;
    end
`else
    assign grant = buf_v_q[0] ? 3'b001 : buf_v_q[1] ? 3'b010 : buf_v_q[2] ? 3'b100 : 3'b000;
`endif

    assign gidx        = grant[1] ? 2'd1 : grant[2] ? 2'd2 : 2'd0;
    assign req_ready   = {3{rst_n}} & (~buf_v_q | grant);
    assign acc         = req_valid & req_ready;
    assign buf_v_d     = acc | (buf_v_q & ~grant);
    // r0 and r24 are hardwired zero: the slot is consumed but the write is dropped.
    assign reg_write_d = |grant && buf_addr_q[gidx] != '0 && buf_addr_q[gidx] != ADDR_W'(24);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_v_q     <= '0;
            reg_write_q <= 1'b0;
            addr3_q     <= '0;
            wdata_q     <= '0;
            for (int i = 0; i < 3; i++) begin
                buf_addr_q[i] <= '0;
                buf_data_q[i] <= '0;
            end
        end else begin
            buf_v_q     <= buf_v_d;
            reg_write_q <= reg_write_d;
            for (int i = 0; i < 3; i++) begin
                if (acc[i]) begin
                    buf_addr_q[i] <= in_addr[i];
                    buf_data_q[i] <= in_data[i];
                end
            end
            if (|grant) begin
                addr3_q <= buf_addr_q[gidx];
                wdata_q <= buf_data_q[gidx];
            end
        end
    end

    assign reg_write = reg_write_q;
    assign addr3     = addr3_q;
    assign wdata     = wdata_q;
    assign idle      = ~|buf_v_q & ~reg_write_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed scoreboard bench for regfile_write_arbiter.
module tb_regfile_write_arbiter;
    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [2:0]  req_valid = '0;
    logic [2:0]  req_ready;
    logic [4:0]  req_addr0 = '0, req_addr1 = '0, req_addr2 = '0;
    logic [31:0] req_data0 = '0, req_data1 = '0, req_data2 = '0;
    logic        reg_write;
    logic [4:0]  addr3;
    logic [31:0] wdata;
    logic        idle;

    int   total = 0;
    int   bad = 0;
    ent_t exp_q[$];
    ent_t sq0[$], sq1[$], sq2[$];
    logic [31:0] rf [32];

    regfile_write_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr0(req_addr0), .req_addr1(req_addr1), .req_addr2(req_addr2),
        .req_data0(req_data0), .req_data1(req_data1), .req_data2(req_data2),
        .reg_write(reg_write), .addr3(addr3), .wdata(wdata), .idle(idle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    // Monitor: every committed write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && reg_write) begin
            rf[addr3] <= wdata;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr3=%0d wdata=%0h expected none", addr3, wdata);
            end else begin
                ent_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(addr3), 32'(e.a));
                chk("wr_data", wdata, e.d);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
    endtask

    function automatic ent_t mk(input logic [4:0] a, input logic [31:0] d);
        mk.a = a;
        mk.d = d;
    endfunction

    task automatic drive(input int maxc, input bit starve);
        logic [2:0] acc;
        ent_t dummy;
        for (int c = 0; c < maxc; c++) begin
            if (sq0.size() == 0 && sq1.size() == 0 && sq2.size() == 0) break;
            req_valid = {sq2.size() != 0, sq1.size() != 0, sq0.size() != 0};
            if (sq0.size() != 0) begin req_addr0 = sq0[0].a; req_data0 = sq0[0].d; end
            if (sq1.size() != 0) begin req_addr1 = sq1[0].a; req_data1 = sq1[0].d; end
            if (sq2.size() != 0) begin req_addr2 = sq2[0].a; req_data2 = sq2[0].d; end
            if (starve && c >= 1) chk("starve_ready2", 32'(req_ready[2]), 32'd0);
            acc = req_valid & req_ready;
            tick();
            if (acc[0]) dummy = sq0.pop_front();
            if (acc[1]) dummy = sq1.pop_front();
            if (acc[2]) dummy = sq2.pop_front();
        end
        req_valid = '0;
        chk("drive_done", 32'(sq0.size() + sq1.size() + sq2.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_reg_write", 32'(reg_write), 32'd0);
        chk("rst_addr3", 32'(addr3), 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        chk("post_rst_ready", 32'(req_ready), 32'd7);

        // Single ALU write, two-cycle latency, one-cycle pulse.
        req_valid = 3'b001; req_addr0 = 5'd5; req_data0 = 32'h1234;
        exp_q.push_back(mk(5'd5, 32'h1234));
        chk("single_ready0", 32'(req_ready[0]), 32'd1);
        tick();
        req_valid = '0;
        chk("single_n1_rw", 32'(reg_write), 32'd0);
        tick();
        chk("single_n2_rw", 32'(reg_write), 32'd1);
        chk("single_n2_addr", 32'(addr3), 32'd5);
        chk("single_n2_data", wdata, 32'h1234);
        tick();
        chk("single_n3_rw", 32'(reg_write), 32'd0);
        chk("single_rf5", rf[5], 32'h1234);

        // Three-way contention from reset, then a second round with sources held.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            sq0.push_back(mk(5'(1 + 3 * i), 32'hA000_0000 + 32'(1 + 3 * i)));
            sq1.push_back(mk(5'(2 + 3 * i), 32'hA000_0000 + 32'(2 + 3 * i)));
            sq2.push_back(mk(5'(3 + 3 * i), 32'hA000_0000 + 32'(3 + 3 * i)));
            if (i == 1) break;
        end
`ifdef RF_ARB_ROUND_ROBIN_EN
        foreach (sq0[i]) begin
            exp_q.push_back(sq0[i]);
            exp_q.push_back(sq1[i]);
            exp_q.push_back(sq2[i]);
        end
`else
        foreach (sq0[i]) exp_q.push_back(sq0[i]);
        foreach (sq1[i]) exp_q.push_back(sq1[i]);
        foreach (sq2[i]) exp_q.push_back(sq2[i]);
`endif
        drive(40, 1'b0);
        repeat (6) tick();
        chk("contention_drain", 32'(exp_q.size()), 32'd0);

`ifndef RF_ARB_ROUND_ROBIN_EN
        // Fixed priority: source 0 streaming starves sources 1 and 2.
        for (int i = 0; i < 10; i++) sq0.push_back(mk(5'(8 + i), 32'hB000_0000 + 32'(i)));
        sq1.push_back(mk(5'd20, 32'hC000_0014));
        sq2.push_back(mk(5'd21, 32'hC000_0015));
        foreach (sq0[i]) exp_q.push_back(sq0[i]);
        exp_q.push_back(sq1[0]);
        exp_q.push_back(sq2[0]);
        drive(40, 1'b1);
        repeat (6) tick();
        chk("starve_drain", 32'(exp_q.size()), 32'd0);
`endif

        // Writes to r0 and r24 are consumed but suppressed.
        req_valid = 3'b001; req_addr0 = 5'd0; req_data0 = 32'hFFFF;
        tick();
        chk("supp_ready0", 32'(req_ready[0]), 32'd1);
        req_addr0 = 5'd24; req_data0 = 32'd7;
        tick();
        req_valid = '0;
        chk("supp0_rw", 32'(reg_write), 32'd0);
        chk("supp0_addr", 32'(addr3), 32'd0);
        chk("supp0_data", wdata, 32'hFFFF);
        tick();
        chk("supp24_rw", 32'(reg_write), 32'd0);
        chk("supp24_addr", 32'(addr3), 32'd24);
        chk("supp24_data", wdata, 32'd7);
        tick();
        chk("supp_idle", 32'(idle), 32'd1);

        // Source 1 streams for 8 cycles without stalling.
        for (int k = 0; k < 8; k++) begin
            req_valid = 3'b010; req_addr1 = 5'(10 + k); req_data1 = 32'h5000_0000 + 32'(k);
            exp_q.push_back(mk(5'(10 + k), 32'h5000_0000 + 32'(k)));
            chk("stream_ready1", 32'(req_ready[1]), 32'd1);
            chk("stream_rw", 32'(reg_write), k >= 2 ? 32'd1 : 32'd0);
            tick();
        end
        req_valid = '0;
        chk("stream_rw8", 32'(reg_write), 32'd1);
        tick();
        chk("stream_rw9", 32'(reg_write), 32'd1);
        tick();
        chk("stream_rw10", 32'(reg_write), 32'd0);
        chk("stream_drain", 32'(exp_q.size()), 32'd0);

        // Reset while two buffers are full and a write is on the port.
        req_valid = 3'b111;
        req_addr0 = 5'd3; req_addr1 = 5'd4; req_addr2 = 5'd5;
        req_data0 = 32'h33; req_data1 = 32'h44; req_data2 = 32'h55;
        tick();
        req_valid = '0;
        tick();
        chk("midrst_pre_rw", 32'(reg_write), 32'd1);
        chk("midrst_pre_idle", 32'(idle), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_rw", 32'(reg_write), 32'd0);
        chk("midrst_addr", 32'(addr3), 32'd0);
        chk("midrst_data", wdata, 32'd0);
        chk("midrst_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        chk("midrst_post_ready", 32'(req_ready), 32'd7);
        chk("midrst_post_idle", 32'(idle), 32'd1);
        repeat (3) tick();
        chk("final_drain", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single register-file write port (`reg_write`, `addr3`, `wdata`) among three writeback sources: ALU, load unit, and multiply/divide unit. Each source gets a one-entry input buffer with a valid/ready handshake. A round-robin arbiter picks one buffered entry per cycle, and the winner is presented to the register file on registered outputs. Writes to r0 and r24, which always read as zero, are consumed but suppressed.

## Interface
- `DATA_W`, 32, write data width.
- `ADDR_W`, 5, register address width.
- `clk`  in  1  system clock; all state updates on posedge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  3  per-source write request; bit i = source i (0 ALU, 1 load, 2 mul/div).
- `req_ready`  out  3  per-source accept; transfer when `req_valid[i] & req_ready[i]`.
- `req_addr0`, `req_addr1`, `req_addr2`  in  ADDR_W  destination register per source.
- `req_data0`, `req_data1`, `req_data2`  in  DATA_W  write data per source.
- `reg_write`  out  1  register-file write enable, registered.
- `addr3`  out  ADDR_W  register-file write address, registered.
- `wdata`  out  DATA_W  register-file write data, registered.
- `idle`  out  1  high when all buffers are empty and `reg_write` is 0.

## Operation
- **Buffers.** Each source i has `buf_v[i]`, `buf_addr[i]` and `buf_data[i]`.
  - `req_ready[i] = rst_n & (~buf_v[i] | grant[i])`.
  - A buffer can drain and refill in the same cycle.
- **Arbitration.** Combinational over `buf_v`; at most one `grant` per cycle.
  - Search starts at index `(last + 1) mod 3`, where `last` is the 2-bit index of the previous grant.
  - `last` updates only on a cycle that has a grant.
- **On a grant to source g:**
  - The buffer clears unless it is refilled in the same cycle.
  - `addr3 <= buf_addr[g]` and `wdata <= buf_data[g]`.
  - `reg_write <= 1` unless `buf_addr[g]` is 0 or 24; for those addresses `reg_write <= 0`, but `addr3` and `wdata` still update.
- **No grant:** `reg_write <= 0`; `addr3` and `wdata` hold their values.
- **Ordering.** No cross-source ordering is enforced. If two sources target the same register, the arbiter's grant order decides. Same-source order is preserved because each buffer holds one entry.
- **`idle`** is `~|buf_v & ~reg_write`.

## Timing
- **Reset values** (asynchronous):
  - `buf_v = 0`, `reg_write = 0`, `addr3 = 0`, `wdata = 0`, `last = 2` (so source 0 wins first).
  - `req_ready = 0` while `rst_n` is low; `idle = 1`.
- **Latency.** An accept in cycle N fills the buffer at posedge N+1. If granted in cycle N+1, `reg_write`, `addr3` and `wdata` are valid for all of cycle N+2.
  - The register file commits on the negedge inside cycle N+2.
  - Minimum latency is 2 cycles.
- **Throughput.** 1 write per cycle in aggregate. A lone source streaming every cycle is never stalled.
- **Contention.** With all three buffers full, each source is granted once every 3 cycles. A waiting buffer is granted within 2 cycles.
- **Reset mid-operation.** Buffered entries are discarded and `reg_write` drops immediately. No partial write reaches the register file after `rst_n` falls.
- **Simultaneous grant and refill.** The new entry enters the buffer; the old entry goes to the output registers.

## Configuration
- **`RF_ARB_ROUND_ROBIN_EN`:**
  - **Defined:** round-robin arbitration as described above.
  - **Undefined:** fixed priority, source 0 > 1 > 2. The `last` register is not implemented; source 2 may starve under sustained load from 0 and 1. All other behaviour is identical.

## Test plan
- **Single ALU write.** After reset, `req_valid = 3'b001`, `req_addr0 = 5`, `req_data0 = 32'h1234` for 1 cycle.
  - Two cycles later: `reg_write = 1`, `addr3 = 5`, `wdata = 32'h1234` for exactly one cycle.
  - r5 reads 32'h1234 afterwards.
- **Three-way contention** (`RF_ARB_ROUND_ROBIN_EN` defined). All sources are valid in the same cycle with addresses 1, 2, 3.
  - `addr3` sequence is 1, 2, 3 on consecutive cycles.
  - A second round of 4, 5, 6, issued while the sources are held, gives 4, 5, 6.
- **Fixed priority** (`RF_ARB_ROUND_ROBIN_EN` undefined). Sources 0 and 1 are continuously valid, and source 2 is valid.
  - Source 2 is never granted.
  - `req_ready[2]` stays 0 after its buffer fills.
- **Suppressed addresses.** Write to r0 with data 32'hFFFF, then to r24 with data 7.
  - `reg_write` stays 0 on both slots; `addr3` shows 0, then 24.
  - `idle` returns to 1.
- **Streaming.** Source 1 is valid for 8 consecutive cycles.
  - `req_ready[1]` stays 1 throughout.
  - `reg_write` is high for 8 consecutive cycles starting 2 cycles after the first accept.
- **Reset mid-operation.** Assert `rst_n = 0` while 2 buffers are full and `reg_write = 1`.
  - `reg_write`, `addr3` and `wdata` go to 0 with no clock edge.
  - After release: `req_ready = 3'b111` and `idle = 1`.
